// File: rtl/bus_pkg.sv
// Shared types and constants for the peripheral bus initiator.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } bus_init_state_t;

    localparam int          BUS_DEFAULT_TIMEOUT = 16;
    localparam logic [31:0] BUS_ERR_RDATA       = 32'h0;

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating cycle counter; expired flags the last permitted cycle of a wait.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Holds at the expiry value instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_initiator.sv
// Bus initiator: one command in, one req/gnt/rvalid transaction, one response out.
// Both command and response ports transfer on the cycle where valid && ready.
module bus_initiator
    import bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = BUS_DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        req,
    output logic        we,
    output logic [3:0]  be,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic        gnt,
    input  logic        rvalid,
    input  logic [31:0] rdata
);

    bus_init_state_t state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            cnt_clr, cnt_en, cnt_expired;

    bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clr),
        .enable  (cnt_en),
        .expired (cnt_expired)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    be_d    = cmd_be;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    cnt_clr = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A grant on the final permitted cycle takes priority over expiry.
                if (gnt) begin
                    cnt_clr = 1'b1;
                    state_d = WAIT;
                end else if (cnt_expired) begin
                    rdata_d = BUS_ERR_RDATA;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            WAIT: begin
                if (rvalid) begin
                    rdata_d = we_q ? 32'h0 : rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_expired) begin
                    rdata_d = BUS_ERR_RDATA;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // req is registered from the next state so it has no path from gnt.
        req_d = (state_d == REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign req       = req_q;
    assign we        = we_q;
    assign be        = be_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;

endmodule

// File: doc/bus_initiator.md
# bus_initiator

Initiator end of the SoC peripheral bus (req/gnt/rvalid). It turns single commands from an upstream valid/ready command port into one bus transaction and returns the result on a valid/ready response port. It sits between a command source (debug bridge, DMA engine) and the peripheral address decoders, which grant in the request cycle and assert rvalid one cycle later. A timeout converts never-granted requests (unmapped offsets) into error responses.

## Interface
- TIMEOUT_CYCLES, default 16: maximum number of cycles req is held without gnt; legal range ≥1.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data.
- cmd_be  in  4  byte enables.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  1 = timeout (no gnt or no rvalid).
- req  out  1  bus request.
- we, be, addr, wdata  out  1/4/32/32  bus attributes, driven from registers.
- gnt  in  1  responder grant, sampled while req=1.
- rvalid  in  1  responder data valid.
- rdata  in  32  responder read data, sampled when rvalid=1.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: cmd_ready=1. On handshake, latch we/addr/wdata/be, clear counter, go to REQ.
- REQ: req=1; attributes are held stable.
  - gnt=1: go to WAIT and clear the counter.
  - gnt=0 with counter < TIMEOUT_CYCLES-1: increment the counter.
  - gnt=0 with counter == TIMEOUT_CYCLES-1: go to RESP with rsp_err=1 and rsp_rdata=0.
  - Result: req is high for at most TIMEOUT_CYCLES cycles. gnt on the final cycle wins over timeout.
- WAIT: req=0.
  - rvalid=1: latch rdata (read) or 0 (write), rsp_err=0, go to RESP.
  - Otherwise the same TIMEOUT_CYCLES counter applies. On expiry: RESP with rsp_err=1, rsp_rdata=0.
- RESP: rsp_valid=1 and outputs stable until rsp_ready. On handshake go to IDLE.
- Ignored inputs: gnt outside REQ, rvalid outside WAIT, and cmd_valid outside IDLE.
- Counter width is $clog2(TIMEOUT_CYCLES+1) and it never wraps.
- Only one transaction is outstanding at a time.

## Timing
- Reset values: state IDLE; req=0, we=0, be=0, addr=0, wdata=0; rsp_valid=0, rsp_rdata=0, rsp_err=0; cmd_ready=1 (IDLE). The counter resets to 0.
- Reset mid-transaction forces req low and rsp_valid low immediately (asynchronous). The pending transaction is discarded with no response.
- Nominal latency, with command handshake at cycle 0:
  - req is high in cycle 1.
  - gnt arrives in cycle 1.
  - rvalid arrives in cycle 2.
  - rsp_valid rises in cycle 3.
  - The next command can be accepted in the cycle after the rsp handshake.
- Timeout latency: rsp_valid rises TIMEOUT_CYCLES+1 cycles after the command handshake.
- req, we, be, addr and wdata come straight from flops, with no combinational path from gnt/rvalid. cmd_ready and rsp_valid are state decodes.

## Structure
- Shared package bus_pkg:
  - bus_init_state_t enum (IDLE, REQ, WAIT, RESP).
  - BUS_DEFAULT_TIMEOUT = 16.
  - BUS_ERR_RDATA = 32'h0.
- One natural sub-module: bus_timeout_counter (clear, enable, expired flag at TIMEOUT_CYCLES-1), shared by the REQ and WAIT states.

## Test plan
- Write: cmd we=1, addr=0x0000_1008, wdata=0x0000_00A5, be=0xF, with a responder model granting in the req cycle. Required: req high for exactly 1 cycle with those attributes; response rsp_err=0, rsp_rdata=0 at cycle 3.
- Read: addr=0x0000_100C, model returns rdata=0x1234_5678 with rvalid one cycle after gnt. Required: rsp_rdata=0x1234_5678, rsp_err=0, rsp_valid at cycle 3.
- Unmapped: addr=0x0000_1FF0, gnt never asserted, TIMEOUT_CYCLES=16. Required: req high exactly 16 cycles; rsp_err=1, rsp_rdata=0 at cycle 17.
- Late grant: gnt first asserted on req cycle 16. Required: normal completion with rsp_err=0 and no timeout.
- Back-pressure: rsp_ready held low 5 cycles. Required: rsp_valid/rsp_rdata/rsp_err stable, cmd_ready=0, and a second cmd_valid not accepted until after the response handshake.
- Reset: assert rst during REQ. Required: req=0 and rsp_valid=0 in the same cycle; after release, cmd_ready=1 and a new read completes normally.
